arbitro_compuerta: RTL and testbench

Arbiter and sequencer for the single shared parking barrier. It grants the barrier to either the entry lane (after the gate controller has validated the PIN) or the exit lane, one vehicle at a time. It tracks occupancy against a capacity limit and flags full/blocked conditions. It sits between the lane sensors plus gate controller outputs and the barrier actuator.

---
 rtl/arbitro_pkg.sv | 25 ++
 rtl/arbitro_compuerta_detector_flanco.sv | 30 +++
 rtl/arbitro_compuerta.sv | 146 ++++++++++++++
 tb/tb_arbitro_compuerta.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Package : arbitro_pkg                                           |
// | Desc    : Shared state and lane encodings for the barrier       |
// |           arbiter and its passage-edge detectors.               |
// | Rev     : 1.0  initial release                                  |
// +-----------------------------------------------------------------+
package arbitro_pkg;

  // Arbiter state; TIMEOUT is only reachable when ARB_TIMEOUT_EN is defined
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERV_IN  = 2'd1,
    SERV_OUT = 2'd2,
    TIMEOUT  = 2'd3
  } estado_t;

  // Lane identifiers, used to remember which lane was served last
  typedef enum logic {
    LANE_IN  = 1'b0,
    LANE_OUT = 1'b1
  } carril_t;

endpackage
`default_nettype wire

// File: rtl/arbitro_compuerta_detector_flanco.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module  : detector_flanco                                       |
// | Desc    : Registered falling-edge detector for one passage      |
// |           sensor. The pulse appears one cycle after the edge    |
// |           where the fall is first seen.                         |
// | Rev     : 1.0  initial release                                  |
// +-----------------------------------------------------------------+
module detector_flanco (
  input  logic clock,
  input  logic reset,
  input  logic sensor,
  output logic flanco
);

  logic previo;

  // Track previous sensor level and register a one-cycle pulse on a 1->0 change
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      previo <= 1'b0;
      flanco <= 1'b0;
    end else begin
      previo <= sensor;
      flanco <= previo & ~sensor;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbitro_compuerta.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module  : arbitro_compuerta                                     |
// | Desc    : Arbiter/sequencer for the shared parking barrier.     |
// |           Grants the barrier to the entry or exit lane, one     |
// |           vehicle at a time, and tracks saturating occupancy.   |
// | Config  : ARB_TIMEOUT_EN - enables the per-grant passage        |
// |           timeout, TIMEOUT state and sAlmTimeout alarm.         |
// | Rev     : 1.0  initial release                                  |
// +-----------------------------------------------------------------+
module arbitro_compuerta
  import arbitro_pkg::*;
#(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sReqIn,
  input  logic             sReqOut,
  input  logic             sBloq,
  input  logic             sPasoIn,
  input  logic             sPasoOut,
  output logic             sGntIn,
  output logic             sGntOut,
  output logic             sAbrir,
  output logic             sLleno,
  output logic [CNT_W-1:0] sOcup,
  output logic             sAlmTimeout
);

  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

  estado_t estado;
  carril_t ultimo;
  logic    fall_in;
  logic    fall_out;
  logic    entrada_ok;

  detector_flanco u_det_in (
    .clock  (clock),
    .reset  (reset),
    .sensor (sPasoIn),
    .flanco (fall_in)
  );

  detector_flanco u_det_out (
    .clock  (clock),
    .reset  (reset),
    .sensor (sPasoOut),
    .flanco (fall_out)
  );

  assign sLleno     = (sOcup == CAP_V);
  assign sAbrir     = sGntIn | sGntOut;
  assign entrada_ok = sReqIn & ~sBloq & ~sLleno;

`ifdef ARB_TIMEOUT_EN
  // Counter holds 0..TIMEOUT_CYC-1, so the grant stays open exactly TIMEOUT_CYC cycles
  localparam int          TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] cuenta;
`endif

  // Main arbiter FSM: lane selection, grant outputs, occupancy and alarm
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= IDLE;
      ultimo      <= LANE_OUT;
      sGntIn      <= 1'b0;
      sGntOut     <= 1'b0;
      sOcup       <= '0;
      sAlmTimeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cuenta      <= '0;
`endif
    end else begin
      case (estado)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          cuenta <= '0;
`endif
          // On contention the lane not served last wins
          if (entrada_ok && (!sReqOut || ultimo == LANE_OUT)) begin
            estado <= SERV_IN;
            sGntIn <= 1'b1;
            ultimo <= LANE_IN;
          end else if (sReqOut) begin
            estado  <= SERV_OUT;
            sGntOut <= 1'b1;
            ultimo  <= LANE_OUT;
          end
        end
        SERV_IN: begin
          if (fall_in) begin
            estado <= IDLE;
            sGntIn <= 1'b0;
            if (sOcup != CAP_V) sOcup <= sOcup + 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cuenta == TLIM) begin
            estado      <= TIMEOUT;
            sGntIn      <= 1'b0;
            sAlmTimeout <= 1'b1;
          end else begin
            cuenta <= cuenta + 1'b1;
          end
`endif
        end
        SERV_OUT: begin
          if (fall_out) begin
            estado  <= IDLE;
            sGntOut <= 1'b0;
            if (sOcup != '0) sOcup <= sOcup - 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cuenta == TLIM) begin
            estado      <= TIMEOUT;
            sGntOut     <= 1'b0;
            sAlmTimeout <= 1'b1;
          end else begin
            cuenta <= cuenta + 1'b1;
          end
`endif
        end
`ifdef ARB_TIMEOUT_EN
        TIMEOUT: begin
          // Wait for the lanes to go completely quiet before rearming
          if (!sReqIn && !sReqOut && !sPasoIn && !sPasoOut) begin
            estado      <= IDLE;
            sAlmTimeout <= 1'b0;
          end
        end
`endif
        default: begin
          estado  <= IDLE;
          sGntIn  <= 1'b0;
          sGntOut <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_compuerta.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module  : tb_arbitro_compuerta                                  |
// | Desc    : Self-checking bench for arbitro_compuerta. Expected   |
// |           occupancy values are queued when a passage is driven  |
// |           and compared when the grant drops.                    |
// | Config  : ARB_TIMEOUT_EN - adds the timeout scenario.           |
// | Rev     : 1.0  initial release                                  |
// +-----------------------------------------------------------------+
module tb_arbitro_compuerta;

  localparam int CAP = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sReqIn = 1'b0, sReqOut = 1'b0, sBloq = 1'b0;
  logic       sPasoIn = 1'b0, sPasoOut = 1'b0;
  logic       sGntIn, sGntOut, sAbrir, sLleno, sAlmTimeout;
  logic [3:0] sOcup;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  int         model_ocup = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;

  arbitro_compuerta #(.CAPACITY(CAP), .CNT_W(4), .TIMEOUT_CYC(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .sReqIn      (sReqIn),
    .sReqOut     (sReqOut),
    .sBloq       (sBloq),
    .sPasoIn     (sPasoIn),
    .sPasoOut    (sPasoOut),
    .sGntIn      (sGntIn),
    .sGntOut     (sGntOut),
    .sAbrir      (sAbrir),
    .sLleno      (sLleno),
    .sOcup       (sOcup),
    .sAlmTimeout (sAlmTimeout)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled on the falling edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    {sReqIn, sReqOut, sBloq, sPasoIn, sPasoOut} = '0;
    tick(2);
    reset = 1'b1;
    model_ocup = 0;
    exp_q.delete();
  endtask

  // Drive a passage on the entry sensor; the grant drops two edges after the fall
  task automatic pass_in();
    sPasoIn = 1'b1; tick();
    sPasoIn = 1'b0; tick(2);
  endtask

  task automatic pass_out();
    sPasoOut = 1'b1; tick();
    sPasoOut = 1'b0; tick(2);
  endtask

  // Full entry transaction with bounded grant wait and scoreboard update
  task automatic do_entry();
    int n;
    n = 0;
    sReqIn = 1'b1;
    while (sGntIn !== 1'b1 && n < 20) begin tick(); n++; end
    sReqIn = 1'b0;
    total_cnt++;
    if (sGntIn !== 1'b1) $display("FAIL entry_grant_wait got=%b want=1", sGntIn); else pass_cnt++;
    if (model_ocup < CAP) model_ocup++;
    exp_q.push_back(4'(model_ocup));
    pass_in();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (sGntIn !== 1'b0 || sOcup !== exp_v)
      $display("FAIL entry_done gnt=%b ocup=%0d want gnt=0 ocup=%0d", sGntIn, sOcup, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++;
    if ({sGntIn, sGntOut, sAbrir, sLleno, sAlmTimeout, sOcup} !== 9'b0)
      $display("FAIL reset_state got=%b want=0", {sGntIn, sGntOut, sAbrir, sLleno, sAlmTimeout, sOcup});
    else pass_cnt++;
  endtask

  task automatic test_single_entry();
    apply_reset();
    sReqIn = 1'b1; tick();
    total_cnt++;
    if ({sGntIn, sGntOut, sAbrir} !== 3'b101)
      $display("FAIL single_grant got=%b want=101", {sGntIn, sGntOut, sAbrir});
    else pass_cnt++;
    sReqIn = 1'b0; tick(3);
    total_cnt++;
    if (sGntIn !== 1'b1) $display("FAIL single_req_drop_holds got=%b want=1", sGntIn); else pass_cnt++;
    exp_q.push_back(4'd1);
    sPasoIn = 1'b1; tick();
    sPasoIn = 1'b0; tick();
    total_cnt++;
    if (sGntIn !== 1'b1) $display("FAIL single_hold_at_fall_edge got=%b want=1", sGntIn); else pass_cnt++;
    tick();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if ({sGntIn, sAbrir} !== 2'b00 || sOcup !== exp_v)
      $display("FAIL single_done gnt/abrir=%b ocup=%0d want 00 ocup=%0d", {sGntIn, sAbrir}, sOcup, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    apply_reset();
    sReqIn = 1'b1; sReqOut = 1'b1; tick();
    total_cnt++;
    if ({sGntIn, sGntOut} !== 2'b10) $display("FAIL contend_first got=%b want=10", {sGntIn, sGntOut}); else pass_cnt++;
    sReqIn = 1'b0;
    // Exit-sensor activity must not end the entry service
    sPasoOut = 1'b1; tick();
    sPasoOut = 1'b0; tick(3);
    total_cnt++;
    if ({sGntIn, sGntOut} !== 2'b10) $display("FAIL contend_ignore_other_lane got=%b want=10", {sGntIn, sGntOut}); else pass_cnt++;
    exp_q.push_back(4'd1);
    pass_in();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if ({sGntIn, sGntOut} !== 2'b00 || sOcup !== exp_v)
      $display("FAIL contend_gap gnt=%b ocup=%0d want 00 ocup=%0d", {sGntIn, sGntOut}, sOcup, exp_v);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({sGntIn, sGntOut} !== 2'b01) $display("FAIL contend_second got=%b want=01", {sGntIn, sGntOut}); else pass_cnt++;
    sReqOut = 1'b0;
    exp_q.push_back(4'd0);
    pass_out();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (sGntOut !== 1'b0 || sOcup !== exp_v)
      $display("FAIL contend_exit_done gnt=%b ocup=%0d want 0 ocup=%0d", sGntOut, sOcup, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < CAP; i++) begin
      do_entry();
      tick();
    end
    total_cnt++;
    if (sLleno !== 1'b1 || sOcup !== 4'd8) $display("FAIL fill_full lleno=%b ocup=%0d want 1 8", sLleno, sOcup); else pass_cnt++;
    sReqIn = 1'b1; tick(5);
    total_cnt++;
    if (sGntIn !== 1'b0) $display("FAIL fill_no_grant_when_full got=%b want=0", sGntIn); else pass_cnt++;
    sReqOut = 1'b1; tick();
    total_cnt++;
    if ({sGntIn, sGntOut} !== 2'b01) $display("FAIL fill_exit_grant got=%b want=01", {sGntIn, sGntOut}); else pass_cnt++;
    sReqOut = 1'b0;
    exp_q.push_back(4'd7);
    pass_out();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (sOcup !== exp_v || sLleno !== 1'b0) $display("FAIL fill_after_exit ocup=%0d lleno=%b want %0d 0", sOcup, sLleno, exp_v); else pass_cnt++;
    tick();
    total_cnt++;
    if (sGntIn !== 1'b1) $display("FAIL fill_pending_entry got=%b want=1", sGntIn); else pass_cnt++;
    sReqIn = 1'b0;
    exp_q.push_back(4'd8);
    pass_in();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (sOcup !== exp_v || sLleno !== 1'b1) $display("FAIL fill_refill ocup=%0d lleno=%b want %0d 1", sOcup, sLleno, exp_v); else pass_cnt++;
  endtask

  task automatic test_bloq();
    apply_reset();
    sBloq = 1'b1; sReqIn = 1'b1; tick(3);
    total_cnt++;
    if (sGntIn !== 1'b0) $display("FAIL bloq_no_entry got=%b want=0", sGntIn); else pass_cnt++;
    sReqOut = 1'b1; tick();
    total_cnt++;
    if ({sGntIn, sGntOut} !== 2'b01) $display("FAIL bloq_exit_served got=%b want=01", {sGntIn, sGntOut}); else pass_cnt++;
    sReqOut = 1'b0; sReqIn = 1'b0;
    exp_q.push_back(4'd0);
    pass_out();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (sOcup !== exp_v || sGntOut !== 1'b0) $display("FAIL bloq_no_underflow ocup=%0d gnt=%b want %0d 0", sOcup, sGntOut, exp_v); else pass_cnt++;
    sBloq = 1'b0; sReqIn = 1'b1; tick();
    sReqIn = 1'b0; sBloq = 1'b1; tick(2);
    total_cnt++;
    if (sGntIn !== 1'b1) $display("FAIL bloq_no_revoke got=%b want=1", sGntIn); else pass_cnt++;
    exp_q.push_back(4'd1);
    pass_in();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (sOcup !== exp_v) $display("FAIL bloq_entry_done ocup=%0d want %0d", sOcup, exp_v); else pass_cnt++;
    sBloq = 1'b0;
  endtask

  task automatic test_long_grant();
    apply_reset();
    sReqOut = 1'b1; tick();
    sReqOut = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tick(63);
    total_cnt++;
    if ({sAbrir, sAlmTimeout} !== 2'b10) $display("FAIL timeout_before abrir/alm=%b want 10", {sAbrir, sAlmTimeout}); else pass_cnt++;
    sReqIn = 1'b1;
    tick();
    total_cnt++;
    if ({sAbrir, sAlmTimeout, sOcup} !== 6'b010000) $display("FAIL timeout_fire abrir/alm/ocup=%b want 010000", {sAbrir, sAlmTimeout, sOcup}); else pass_cnt++;
    tick(3);
    total_cnt++;
    if ({sAbrir, sAlmTimeout} !== 2'b01) $display("FAIL timeout_hold abrir/alm=%b want 01", {sAbrir, sAlmTimeout}); else pass_cnt++;
    sReqIn = 1'b0; tick();
    total_cnt++;
    if (sAlmTimeout !== 1'b0) $display("FAIL timeout_clear got=%b want=0", sAlmTimeout); else pass_cnt++;
    sReqIn = 1'b1; tick();
    total_cnt++;
    if (sGntIn !== 1'b1) $display("FAIL timeout_rearm got=%b want=1", sGntIn); else pass_cnt++;
    sReqIn = 1'b0;
`else
    tick(100);
    total_cnt++;
    if ({sGntOut, sAbrir, sAlmTimeout} !== 3'b110) $display("FAIL long_grant_held got=%b want=110", {sGntOut, sAbrir, sAlmTimeout}); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_entry();
      tick();
    end
    sReqOut = 1'b1; tick();
    total_cnt++;
    if (sGntOut !== 1'b1 || sOcup !== 4'd3) $display("FAIL mid_setup gnt=%b ocup=%0d want 1 3", sGntOut, sOcup); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if ({sGntOut, sAbrir} !== 2'b00 || sOcup !== 4'd0)
      $display("FAIL mid_async_reset gnt/abrir=%b ocup=%0d want 00 0", {sGntOut, sAbrir}, sOcup);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
    sReqIn = 1'b1; sReqOut = 1'b1; tick();
    total_cnt++;
    if ({sGntIn, sGntOut} !== 2'b10) $display("FAIL mid_entry_wins got=%b want=10", {sGntIn, sGntOut}); else pass_cnt++;
    sReqIn = 1'b0; sReqOut = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_contention();
    test_fill();
    test_bloq();
    test_long_grant();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
